// File: rtl/pifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// pifo_port_arbiter
//
// Shares the single push/pop port of the virtualized PIFO tree among NREQ
// requesters. Push and pop each have an independent round-robin arbiter.
// Per-tree occupancy counters gate admission, so a full tree is never pushed
// and an empty tree is never popped. All tree-side outputs are registered.
//
// Ports:
//   i_clk, i_arst_n         clock, asynchronous active-low reset
//   i_req_push              per-requester push valid
//   i_req_push_priority     packed push priorities (requester i = slice i)
//   i_req_push_tree_id      packed push tree ids
//   i_req_push_data         packed push data (MTW+PTW bits each)
//   o_req_push_ready        push grant, one-hot or zero, combinational
//   i_req_pop               per-requester pop valid
//   i_req_pop_tree_id       packed pop tree ids
//   o_req_pop_ready         pop grant, one-hot or zero, combinational
//   i_pifo_ready            PIFO tree can accept a push/pop this cycle
//   o_push, o_push_*        registered push strobe and fields
//   o_pop, o_pop_tree_id    registered pop strobe and tree id
//   o_push_grant_id         requester index of the latest push
//   o_pop_grant_id          requester index of the latest pop
//   o_tree_occupancy        packed per-tree occupancy counters
// -----------------------------------------------------------------------------
module pifo_port_arbiter #(
    parameter int PTW      = 16,
    parameter int MTW      = 16,
    parameter int TREE_NUM = 4,
    parameter int NREQ     = 4,
    parameter int TREE_CAP = 1024,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int NREQ_BITS     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_BITS      = $clog2(TREE_CAP + 1),
    localparam int DW            = MTW + PTW
) (
    input  logic                              i_clk,
    input  logic                              i_arst_n,
    input  logic [NREQ-1:0]                   i_req_push,
    input  logic [NREQ*PTW-1:0]               i_req_push_priority,
    input  logic [NREQ*TREE_NUM_BITS-1:0]     i_req_push_tree_id,
    input  logic [NREQ*DW-1:0]                i_req_push_data,
    output logic [NREQ-1:0]                   o_req_push_ready,
    input  logic [NREQ-1:0]                   i_req_pop,
    input  logic [NREQ*TREE_NUM_BITS-1:0]     i_req_pop_tree_id,
    output logic [NREQ-1:0]                   o_req_pop_ready,
    input  logic                              i_pifo_ready,
    output logic                              o_push,
    output logic [PTW-1:0]                    o_push_priority,
    output logic [TREE_NUM_BITS-1:0]          o_push_tree_id,
    output logic [DW-1:0]                     o_push_data,
    output logic                              o_pop,
    output logic [TREE_NUM_BITS-1:0]          o_pop_tree_id,
    output logic [NREQ_BITS-1:0]              o_push_grant_id,
    output logic [NREQ_BITS-1:0]              o_pop_grant_id,
    output logic [TREE_NUM*CNT_BITS-1:0]      o_tree_occupancy
);

    // Round-robin search: first eligible index starting at ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [NREQ_BITS:0] rrPick(
        input logic [NREQ-1:0]      elig,
        input logic [NREQ_BITS-1:0] ptr
    );
        logic                 found;
        logic [NREQ_BITS-1:0] sel;
        int                   idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = NREQ_BITS'(idx);
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [NREQ_BITS-1:0] nextPtr(input logic [NREQ_BITS-1:0] idx);
        return NREQ_BITS'((int'(idx) + 1) % NREQ);
    endfunction

    logic [CNT_BITS-1:0]      r_occ [TREE_NUM];
    logic [NREQ_BITS-1:0]     r_pushPtr;
    logic [NREQ_BITS-1:0]     r_popPtr;

    logic                     r_push;
    logic [PTW-1:0]           r_pushPrio;
    logic [TREE_NUM_BITS-1:0] r_pushTree;
    logic [DW-1:0]            r_pushData;
    logic                     r_pop;
    logic [TREE_NUM_BITS-1:0] r_popTree;
    logic [NREQ_BITS-1:0]     r_pushGid;
    logic [NREQ_BITS-1:0]     r_popGid;

    logic [TREE_NUM_BITS-1:0] w_pushTid [NREQ];
    logic [TREE_NUM_BITS-1:0] w_popTid  [NREQ];
    logic [NREQ-1:0]          w_pushElig;
    logic [NREQ-1:0]          w_popElig;
    logic [NREQ_BITS:0]       w_pushPick;
    logic [NREQ_BITS:0]       w_popPick;
    logic                     w_pushFire;
    logic                     w_popFire;
    logic [NREQ_BITS-1:0]     w_pushIdx;
    logic [NREQ_BITS-1:0]     w_popIdx;
    logic [NREQ-1:0]          w_pushGrant;
    logic [NREQ-1:0]          w_popGrant;
    logic [PTW-1:0]           w_pushPrioSel;
    logic [DW-1:0]            w_pushDataSel;
    logic [TREE_NUM_BITS-1:0] w_pushTidSel;
    logic [TREE_NUM_BITS-1:0] w_popTidSel;

    // Eligibility looks only at the registered counts, so a same-cycle push
    // cannot enable a pop and a same-cycle pop cannot make room for a push.
    always_comb begin
        w_pushElig = '0;
        w_popElig  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pushTid[i] = i_req_push_tree_id[i*TREE_NUM_BITS +: TREE_NUM_BITS];
            w_popTid[i]  = i_req_pop_tree_id[i*TREE_NUM_BITS +: TREE_NUM_BITS];
            if (i_req_push[i] && (int'(w_pushTid[i]) < TREE_NUM))
                w_pushElig[i] = (r_occ[w_pushTid[i]] < CNT_BITS'(TREE_CAP));
            if (i_req_pop[i] && (int'(w_popTid[i]) < TREE_NUM))
                w_popElig[i] = (r_occ[w_popTid[i]] != '0);
        end
    end

    assign w_pushPick = rrPick(w_pushElig, r_pushPtr);
    assign w_popPick  = rrPick(w_popElig, r_popPtr);
    assign w_pushIdx  = w_pushPick[NREQ_BITS-1:0];
    assign w_popIdx   = w_popPick[NREQ_BITS-1:0];

    // Readies are also held low during reset so nothing is handshaken that
    // the reset is about to discard.
    assign w_pushFire = w_pushPick[NREQ_BITS] && i_pifo_ready && i_arst_n;
    assign w_popFire  = w_popPick[NREQ_BITS]  && i_pifo_ready && i_arst_n;

    always_comb begin
        w_pushGrant = '0;
        w_popGrant  = '0;
        if (w_pushFire) w_pushGrant[w_pushIdx] = 1'b1;
        if (w_popFire)  w_popGrant[w_popIdx]   = 1'b1;
    end

    assign o_req_push_ready = w_pushGrant;
    assign o_req_pop_ready  = w_popGrant;

    assign w_pushPrioSel = i_req_push_priority[int'(w_pushIdx)*PTW +: PTW];
    assign w_pushDataSel = i_req_push_data[int'(w_pushIdx)*DW +: DW];
    assign w_pushTidSel  = w_pushTid[w_pushIdx];
    assign w_popTidSel   = w_popTid[w_popIdx];

    // Round-robin pointers advance past the granted requester only.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_pushPtr <= '0;
            r_popPtr  <= '0;
        end else begin
            if (w_pushFire) r_pushPtr <= nextPtr(w_pushIdx);
            if (w_popFire)  r_popPtr  <= nextPtr(w_popIdx);
        end
    end

    // A push and a pop hitting the same tree cancel out. Bounds are already
    // guaranteed by eligibility.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int t = 0; t < TREE_NUM; t++) r_occ[t] <= '0;
        end else begin
            for (int t = 0; t < TREE_NUM; t++) begin
                if ((w_pushFire && int'(w_pushTidSel) == t) &&
                    !(w_popFire && int'(w_popTidSel) == t))
                    r_occ[t] <= r_occ[t] + CNT_BITS'(1);
                else if ((w_popFire && int'(w_popTidSel) == t) &&
                         !(w_pushFire && int'(w_pushTidSel) == t))
                    r_occ[t] <= r_occ[t] - CNT_BITS'(1);
            end
        end
    end

    // Tree-side output registers. Idle push fields return to all-ones/zero;
    // grant ids keep the last granted requester.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_push     <= 1'b0;
            r_pushPrio <= '1;
            r_pushTree <= '0;
            r_pushData <= '1;
            r_pop      <= 1'b0;
            r_popTree  <= '0;
            r_pushGid  <= '0;
            r_popGid   <= '0;
        end else begin
            r_push <= w_pushFire;
            r_pop  <= w_popFire;
            if (w_pushFire) begin
                r_pushPrio <= w_pushPrioSel;
                r_pushTree <= w_pushTidSel;
                r_pushData <= w_pushDataSel;
                r_pushGid  <= w_pushIdx;
            end else begin
                r_pushPrio <= '1;
                r_pushTree <= '0;
                r_pushData <= '1;
            end
            if (w_popFire) begin
                r_popTree <= w_popTidSel;
                r_popGid  <= w_popIdx;
            end else begin
                r_popTree <= '0;
            end
        end
    end

    assign o_push          = r_push;
    assign o_push_priority = r_pushPrio;
    assign o_push_tree_id  = r_pushTree;
    assign o_push_data     = r_pushData;
    assign o_pop           = r_pop;
    assign o_pop_tree_id   = r_popTree;
    assign o_push_grant_id = r_pushGid;
    assign o_pop_grant_id  = r_popGid;

    for (genvar t = 0; t < TREE_NUM; t++) begin : g_occ
        assign o_tree_occupancy[t*CNT_BITS +: CNT_BITS] = r_occ[t];
    end

endmodule

// File: tb/tb_pifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pifo_port_arbiter
//
// Directed bench for pifo_port_arbiter, built with TREE_CAP=4 so the full-tree
// stall is reachable in a few cycles. A table of per-cycle vectors carries the
// hand-computed readies and post-edge occupancies; reset and async-reset
// corners are written out as short sequences.
// -----------------------------------------------------------------------------
module tb_pifo_port_arbiter;

    localparam int PTW  = 16;
    localparam int MTW  = 16;
    localparam int TN   = 4;
    localparam int NREQ = 4;
    localparam int CAP  = 4;
    localparam int TNB  = 2;
    localparam int NRB  = 2;
    localparam int CNT  = 3;
    localparam int DW   = MTW + PTW;
    localparam int NVEC = 23;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       reqPush;
    logic [NREQ*PTW-1:0]   reqPushPrio;
    logic [NREQ*TNB-1:0]   reqPushTree;
    logic [NREQ*DW-1:0]    reqPushData;
    logic [NREQ-1:0]       reqPushReady;
    logic [NREQ-1:0]       reqPop;
    logic [NREQ*TNB-1:0]   reqPopTree;
    logic [NREQ-1:0]       reqPopReady;
    logic                  pifoReady;
    logic                  push;
    logic [PTW-1:0]        pushPrio;
    logic [TNB-1:0]        pushTree;
    logic [DW-1:0]         pushData;
    logic                  pop;
    logic [TNB-1:0]        popTree;
    logic [NRB-1:0]        pushGid;
    logic [NRB-1:0]        popGid;
    logic [TN*CNT-1:0]     occ;

    pifo_port_arbiter #(
        .PTW(PTW), .MTW(MTW), .TREE_NUM(TN), .NREQ(NREQ), .TREE_CAP(CAP)
    ) dut (
        .i_clk               (clk),
        .i_arst_n            (rst_n),
        .i_req_push          (reqPush),
        .i_req_push_priority (reqPushPrio),
        .i_req_push_tree_id  (reqPushTree),
        .i_req_push_data     (reqPushData),
        .o_req_push_ready    (reqPushReady),
        .i_req_pop           (reqPop),
        .i_req_pop_tree_id   (reqPopTree),
        .o_req_pop_ready     (reqPopReady),
        .i_pifo_ready        (pifoReady),
        .o_push              (push),
        .o_push_priority     (pushPrio),
        .o_push_tree_id      (pushTree),
        .o_push_data         (pushData),
        .o_pop               (pop),
        .o_pop_tree_id       (popTree),
        .o_push_grant_id     (pushGid),
        .o_pop_grant_id      (popGid),
        .o_tree_occupancy    (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  push;
        logic [7:0]  pushTree;
        logic [3:0]  pop;
        logic [7:0]  popTree;
        logic        rdy;
        logic [3:0]  expPushRdy;
        logic [3:0]  expPopRdy;
        logic [11:0] expOcc;     // {occ3, occ2, occ1, occ0}
    } vec_t;

    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    logic [NRB-1:0] expPushGid;
    logic [NRB-1:0] expPopGid;

    function automatic logic [PTW-1:0] prioOf(input int k, input int i);
        return PTW'(256 + k*16 + i);
    endfunction

    function automatic logic [DW-1:0] dataOf(input int k, input int i);
        return 32'hCAFE0000 + DW'(k*256 + i);
    endfunction

    function automatic int idxOf(input logic [3:0] oneHot);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++) if (oneHot[i]) r = i;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        reqPush     = '0;
        reqPushPrio = '0;
        reqPushTree = '0;
        reqPushData = '0;
        reqPop      = '0;
        reqPopTree  = '0;
        pifoReady   = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_push"},     64'(push),     64'(0));
        checkOutput({tag, "_pop"},      64'(pop),      64'(0));
        checkOutput({tag, "_prio"},     64'(pushPrio), 64'(16'hFFFF));
        checkOutput({tag, "_ptree"},    64'(pushTree), 64'(0));
        checkOutput({tag, "_data"},     64'(pushData), 64'(32'hFFFFFFFF));
        checkOutput({tag, "_poptree"},  64'(popTree),  64'(0));
        checkOutput({tag, "_gids"},     64'({pushGid, popGid}), 64'(0));
        checkOutput({tag, "_occ"},      64'(occ),      64'(0));
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expPushGid = '0;
        expPopGid  = '0;
    endtask

    task automatic applyStimulus(input vec_t v, input int k);
        @(negedge clk);
        reqPush    = v.push;
        reqPushTree = v.pushTree;
        reqPop     = v.pop;
        reqPopTree = v.popTree;
        pifoReady  = v.rdy;
        for (int i = 0; i < NREQ; i++) begin
            reqPushPrio[i*PTW +: PTW] = prioOf(k, i);
            reqPushData[i*DW +: DW]   = dataOf(k, i);
        end
    endtask

    // T: requester i targets tree i
    localparam logic [7:0] T   = 8'b11_10_01_00;
    localparam logic [7:0] ALL0 = 8'h00;
    localparam logic [7:0] ALL2 = 8'hAA;
    localparam logic [7:0] ALL3 = 8'hFF;

    initial begin
        // Round robin over four distinct trees, starting from a fresh reset
        vecs[0]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0001, 4'b0000, {3'd0,3'd0,3'd0,3'd1}};
        vecs[1]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0010, 4'b0000, {3'd0,3'd0,3'd1,3'd1}};
        vecs[2]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0100, 4'b0000, {3'd0,3'd1,3'd1,3'd1}};
        vecs[3]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b1000, 4'b0000, {3'd1,3'd1,3'd1,3'd1}};
        vecs[4]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0001, 4'b0000, {3'd1,3'd1,3'd1,3'd2}};
        vecs[5]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0010, 4'b0000, {3'd1,3'd1,3'd2,3'd2}};
        vecs[6]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b0100, 4'b0000, {3'd1,3'd2,3'd2,3'd2}};
        vecs[7]  = '{4'b1111, T, 4'b0000, ALL0, 1'b1, 4'b1000, 4'b0000, {3'd2,3'd2,3'd2,3'd2}};
        // Drain tree 2, then pop of an empty tree stalls
        vecs[8]  = '{4'b0000, T, 4'b0001, ALL2, 1'b1, 4'b0000, 4'b0001, {3'd2,3'd1,3'd2,3'd2}};
        vecs[9]  = '{4'b0000, T, 4'b0010, ALL2, 1'b1, 4'b0000, 4'b0010, {3'd2,3'd0,3'd2,3'd2}};
        vecs[10] = '{4'b0000, T, 4'b0100, ALL2, 1'b1, 4'b0000, 4'b0000, {3'd2,3'd0,3'd2,3'd2}};
        // Same-cycle push does not enable the pop; pop follows next cycle
        vecs[11] = '{4'b0100, T, 4'b0100, ALL2, 1'b1, 4'b0100, 4'b0000, {3'd2,3'd1,3'd2,3'd2}};
        vecs[12] = '{4'b0000, T, 4'b0100, ALL2, 1'b1, 4'b0000, 4'b0100, {3'd2,3'd0,3'd2,3'd2}};
        // Fill tree 0 to capacity, stall, pop frees room one cycle later
        vecs[13] = '{4'b0001, T, 4'b0000, ALL0, 1'b1, 4'b0001, 4'b0000, {3'd2,3'd0,3'd2,3'd3}};
        vecs[14] = '{4'b0001, T, 4'b0000, ALL0, 1'b1, 4'b0001, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        vecs[15] = '{4'b0001, T, 4'b0000, ALL0, 1'b1, 4'b0000, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        vecs[16] = '{4'b0001, T, 4'b0010, ALL0, 1'b1, 4'b0000, 4'b0010, {3'd2,3'd0,3'd2,3'd3}};
        vecs[17] = '{4'b0001, T, 4'b0000, ALL0, 1'b1, 4'b0001, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        // Push and pop of tree 3 in one cycle leave the count unchanged
        vecs[18] = '{4'b1000, T, 4'b1000, ALL3, 1'b1, 4'b1000, 4'b1000, {3'd2,3'd0,3'd2,3'd4}};
        // PIFO not ready: nothing granted, pointers hold
        vecs[19] = '{4'b1111, T, 4'b1111, ALL3, 1'b0, 4'b0000, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        vecs[20] = '{4'b1111, T, 4'b1111, ALL3, 1'b0, 4'b0000, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        vecs[21] = '{4'b1111, T, 4'b1111, ALL3, 1'b0, 4'b0000, 4'b0000, {3'd2,3'd0,3'd2,3'd4}};
        vecs[22] = '{4'b1111, T, 4'b1111, ALL3, 1'b1, 4'b0010, 4'b0001, {3'd1,3'd0,3'd3,3'd4}};

        // Reset state, checked while reset is held
        rst_n = 1'b0;
        clearInputs();
        #12;
        checkResetOutputs("reset");
        applyReset();

        // Single push: requester 0, prio 5, tree 1, data 0xAB
        @(negedge clk);
        reqPush[0]           = 1'b1;
        reqPushPrio[0 +: PTW] = 16'd5;
        reqPushTree[0 +: TNB] = 2'd1;
        reqPushData[0 +: DW]  = 32'hAB;
        #1;
        checkOutput("t1_ready", 64'(reqPushReady), 64'(4'b0001));
        @(posedge clk); #1;
        checkOutput("t1_push",  64'(push),     64'(1));
        checkOutput("t1_prio",  64'(pushPrio), 64'(5));
        checkOutput("t1_tree",  64'(pushTree), 64'(1));
        checkOutput("t1_data",  64'(pushData), 64'(32'hAB));
        checkOutput("t1_gid",   64'(pushGid),  64'(0));
        checkOutput("t1_occ",   64'(occ),      64'({3'd0,3'd0,3'd1,3'd0}));
        @(negedge clk);
        reqPush = '0;
        @(posedge clk); #1;
        checkOutput("t1_idle_push", 64'(push),     64'(0));
        checkOutput("t1_idle_prio", 64'(pushPrio), 64'(16'hFFFF));
        checkOutput("t1_idle_data", 64'(pushData), 64'(32'hFFFFFFFF));

        // Table-driven sequence from a fresh reset
        applyReset();
        for (int k = 0; k < NVEC; k++) begin
            int g;
            applyStimulus(vecs[k], k);
            #1;
            checkOutput($sformatf("v%0d_push_rdy", k), 64'(reqPushReady), 64'(vecs[k].expPushRdy));
            checkOutput($sformatf("v%0d_pop_rdy", k),  64'(reqPopReady),  64'(vecs[k].expPopRdy));
            @(posedge clk); #1;
            if (vecs[k].expPushRdy != 4'b0000) begin
                g = idxOf(vecs[k].expPushRdy);
                expPushGid = NRB'(g);
                checkOutput($sformatf("v%0d_push", k),  64'(push),     64'(1));
                checkOutput($sformatf("v%0d_prio", k),  64'(pushPrio), 64'(prioOf(k, g)));
                checkOutput($sformatf("v%0d_ptree", k), 64'(pushTree), 64'(vecs[k].pushTree[g*2 +: 2]));
                checkOutput($sformatf("v%0d_data", k),  64'(pushData), 64'(dataOf(k, g)));
            end else begin
                checkOutput($sformatf("v%0d_push", k),  64'(push),     64'(0));
                checkOutput($sformatf("v%0d_prio", k),  64'(pushPrio), 64'(16'hFFFF));
                checkOutput($sformatf("v%0d_ptree", k), 64'(pushTree), 64'(0));
            end
            if (vecs[k].expPopRdy != 4'b0000) begin
                g = idxOf(vecs[k].expPopRdy);
                expPopGid = NRB'(g);
                checkOutput($sformatf("v%0d_pop", k),     64'(pop),     64'(1));
                checkOutput($sformatf("v%0d_poptree", k), 64'(popTree), 64'(vecs[k].popTree[g*2 +: 2]));
            end else begin
                checkOutput($sformatf("v%0d_pop", k),     64'(pop),     64'(0));
                checkOutput($sformatf("v%0d_poptree", k), 64'(popTree), 64'(0));
            end
            checkOutput($sformatf("v%0d_push_gid", k), 64'(pushGid), 64'(expPushGid));
            checkOutput($sformatf("v%0d_pop_gid", k),  64'(popGid),  64'(expPopGid));
            checkOutput($sformatf("v%0d_occ", k),      64'(occ),     64'(vecs[k].expOcc));
        end

        // Async reset mid-operation: bring occ[0] to 3 with a push in flight
        @(negedge clk);
        clearInputs();
        reqPop[0]             = 1'b1;
        reqPopTree[0 +: TNB]  = 2'd0;
        reqPush[1]            = 1'b1;
        reqPushTree[2 +: TNB] = 2'd1;
        @(posedge clk); #1;
        checkOutput("ar_push_before", 64'(push), 64'(1));
        checkOutput("ar_occ_before",  64'(occ),  64'({3'd1,3'd0,3'd4,3'd3}));
        reqPop                = '0;
        reqPush               = 4'b0100;
        reqPushTree[4 +: TNB] = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("ar_during");
        @(negedge clk);
        clearInputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("ar_after_push", 64'(push), 64'(0));
            checkOutput("ar_after_pop",  64'(pop),  64'(0));
            checkOutput("ar_after_occ",  64'(occ),  64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
